// File: rtl/ftoi_pipe.sv
// ftoi_pipe: pipelined IEEE-754 binary32 to INT_W-bit integer converter with dynamic rounding.
// Define FTOI_PIPE_FLAGS_EN to compute and register fflags; otherwise fflags is tied to 0.
module ftoi_pipe #(
    parameter int INT_W     = 32,
    parameter int PIPE_REGS = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             order,
    output logic             accepted,
    output logic             done,
    input  logic [31:0]      rs1,
    input  logic [2:0]       rm,
    input  logic             is_unsigned,
    output logic [INT_W-1:0] rd,
    output logic [4:0]       fflags
);
    // Handshake: accepted follows order whenever rstn is high; there is no backpressure,
    // so every accepted op produces exactly one done pulse PIPE_REGS cycles later, in order.
    typedef struct packed {
        logic             v;
        logic             sign;
        logic             nan;
        logic             inf;
        logic             big;   // |value| >= 2^INT_W before rounding
        logic [INT_W-1:0] ip;
        logic             g;
        logic             st;
        logic [2:0]       rm;
        logic             uns;
    } dec_t;

    dec_t              d;
    dec_t              s;
    logic [7:0]        ex;
    logic [7:0]        sh;
    logic [INT_W+23:0] wide;
    logic              inc;
    logic [INT_W:0]    mag;
    logic              sat;
    logic [INT_W-1:0]  pos_sat;
    logic [INT_W-1:0]  neg_sat;
    logic [INT_W-1:0]  res;

    assign accepted = order & rstn;
    assign ex       = rs1[30:23];
    assign sh       = ex - 8'd126;
    // Significand scaled by 2^(e+1): integer part above bit 24, guard at bit 23, sticky below.
    assign wide     = {{INT_W{1'b0}}, 1'b1, rs1[22:0]} << sh;

    always_comb begin
        d      = '0;
        d.v    = accepted;
        d.sign = rs1[31];
        d.rm   = rm;
        d.uns  = is_unsigned;
        if (ex == 8'hff) begin
            d.nan = |rs1[22:0];
            d.inf = ~|rs1[22:0];
        end else if ({1'b0, ex} >= 9'(127 + INT_W)) begin
            d.big = 1'b1;
        end else if (ex >= 8'd126) begin
            d.ip = wide[INT_W+23:24];
            d.g  = wide[23];
            d.st = |wide[22:0];
        end else begin
            d.st = (ex != 8'd0) | (|rs1[22:0]);
        end
    end

    generate
        if (PIPE_REGS >= 2) begin : g_stage1
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s <= '0;
                end else begin
                    s <= d;
                end
            end
        end else begin : g_comb
            assign s = d;
        end
    endgenerate

    always_comb begin
        case (s.rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = s.sign & (s.g | s.st);
            3'b011:  inc = ~s.sign & (s.g | s.st);
            3'b100:  inc = s.g;
            default: inc = s.g & (s.st | s.ip[0]);
        endcase
    end

    assign mag     = {1'b0, s.ip} + {{INT_W{1'b0}}, inc};
    assign pos_sat = s.uns ? '1 : {1'b0, {(INT_W-1){1'b1}}};
    assign neg_sat = s.uns ? '0 : {1'b1, {(INT_W-1){1'b0}}};

    // Range check after rounding, so a carry out of the top bit saturates too.
    always_comb begin
        if (s.nan | s.inf) begin
            sat = 1'b1;
        end else if (s.uns) begin
            sat = s.sign ? (s.big | (|mag)) : (s.big | mag[INT_W]);
        end else if (s.sign) begin
            sat = s.big | mag[INT_W] | (mag[INT_W-1] & (|mag[INT_W-2:0]));
        end else begin
            sat = s.big | mag[INT_W] | mag[INT_W-1];
        end
    end

    assign res = sat ? ((s.sign & ~s.nan) ? neg_sat : pos_sat)
                     : ((s.sign & ~s.uns) ? (-mag[INT_W-1:0]) : mag[INT_W-1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done <= 1'b0;
            rd   <= '0;
        end else begin
            done <= s.v;
            if (s.v) begin
                rd <= res;
            end
        end
    end

`ifdef FTOI_PIPE_FLAGS_EN
    // Every saturating case is an invalid operation, which also masks inexact.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fflags <= '0;
        end else if (s.v) begin
            fflags <= {sat, 3'b000, ~sat & (s.g | s.st)};
        end
    end
`else
    assign fflags = 5'b00000;
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: three instances (32b/2-stage, 32b/1-stage, 8b/2-stage) share one stimulus
// stream; a real-arithmetic reference model and directed constants feed per-instance expected queues.
`timescale 1ns/1ps
module tb_ftoi_pipe;
    localparam int EW = 101;  // {issue cycle[31:0], fflags[4:0], rd[63:0]}

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        order = 1'b0;
    logic        is_unsigned = 1'b0;
    logic [31:0] rs1 = '0;
    logic [2:0]  rm = '0;
    logic        acc_a, acc_b, acc_c, done_a, done_b, done_c;
    logic [31:0] rd_a, rd_b;
    logic [7:0]  rd_c;
    logic [4:0]  ff_a, ff_b, ff_c;

    logic [EW-1:0] exp_q_a[$];
    logic [EW-1:0] exp_q_b[$];
    logic [EW-1:0] exp_q_c[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    ftoi_pipe #(.INT_W(32), .PIPE_REGS(2)) dut_a (
        .clk(clk), .rstn(rstn), .order(order), .accepted(acc_a), .done(done_a),
        .rs1(rs1), .rm(rm), .is_unsigned(is_unsigned), .rd(rd_a), .fflags(ff_a));
    ftoi_pipe #(.INT_W(32), .PIPE_REGS(1)) dut_b (
        .clk(clk), .rstn(rstn), .order(order), .accepted(acc_b), .done(done_b),
        .rs1(rs1), .rm(rm), .is_unsigned(is_unsigned), .rd(rd_b), .fflags(ff_b));
    ftoi_pipe #(.INT_W(8), .PIPE_REGS(2)) dut_c (
        .clk(clk), .rstn(rstn), .order(order), .accepted(acc_c), .done(done_c),
        .rs1(rs1), .rm(rm), .is_unsigned(is_unsigned), .rd(rd_c), .fflags(ff_c));

    function automatic logic [4:0] mask_flags(input logic [4:0] f);
`ifdef FTOI_PIPE_FLAGS_EN
        return f;
`else
        return 5'b00000 & f;
`endif
    endfunction

    // Reference: exact value as a real, rounded with floor/ceil, then range-checked.
    function automatic logic [68:0] model(input logic [31:0] a, input logic [2:0] m,
                                          input logic u, input int w);
        logic [63:0] mask, pos_sat, neg_sat, res;
        logic        nv, nx;
        real         x, r, fl, d, hi, lo, p;
        int          k;
        mask    = (64'd1 << w) - 64'd1;
        pos_sat = u ? mask : ((64'd1 << (w - 1)) - 64'd1);
        neg_sat = u ? 64'd0 : ~((64'd1 << (w - 1)) - 64'd1);
        p = 1.0;
        for (int i = 0; i < w; i++) p = p * 2.0;
        hi = u ? p - 1.0 : p / 2.0 - 1.0;
        lo = u ? 0.0 : -(p / 2.0);
        nx = 1'b0;
        if (a[30:23] == 8'hff) begin
            nv  = 1'b1;
            res = (a[31] && a[22:0] == 23'd0) ? neg_sat : pos_sat;
        end else begin
            if (a[30:23] == 8'd0) begin
                x = $itor({9'd0, a[22:0]});
                k = -149;
            end else begin
                x = $itor({8'd0, 1'b1, a[22:0]});
                k = int'({24'd0, a[30:23]}) - 150;
            end
            while (k > 0) begin x = x * 2.0; k--; end
            while (k < 0) begin x = x / 2.0; k++; end
            if (a[31]) x = -x;
            fl = $floor(x);
            d  = x - fl;
            case (m)
                3'd1:    r = (x < 0.0) ? $ceil(x) : fl;
                3'd2:    r = fl;
                3'd3:    r = $ceil(x);
                3'd4:    r = (d > 0.5 || (d == 0.5 && x > 0.0)) ? fl + 1.0 : fl;
                default: r = (d > 0.5 || (d == 0.5 && $floor(fl / 2.0) != fl / 2.0)) ? fl + 1.0 : fl;
            endcase
            nv = (r > hi) || (r < lo);
            if (r > hi)      res = pos_sat;
            else if (r < lo) res = neg_sat;
            else             res = 64'(longint'(r));
            nx = !nv && (r != x);
        end
        return {nv, 3'b000, nx, res & mask};
    endfunction

    // One clock step: scoreboard pops on done at the falling edge, inputs change just after rising.
    task automatic tick();
        logic [EW-1:0] e;
        @(negedge clk);
        if (done_a) begin
            checks++;
            if (exp_q_a.size() == 0) begin
                errors++;
                $display("FAIL dut_a unexpected done: rd=%h", rd_a);
            end else begin
                e = exp_q_a.pop_front();
                if ({ff_a, rd_a} !== {e[68:64], e[31:0]} || cyc - int'(e[100:69]) != 2) begin
                    errors++;
                    $display("FAIL dut_a result: rd=%h fflags=%b latency=%0d, expected rd=%h fflags=%b latency=2",
                             rd_a, ff_a, cyc - int'(e[100:69]), e[31:0], e[68:64]);
                end
            end
        end
        if (done_b) begin
            checks++;
            if (exp_q_b.size() == 0) begin
                errors++;
                $display("FAIL dut_b unexpected done: rd=%h", rd_b);
            end else begin
                e = exp_q_b.pop_front();
                if ({ff_b, rd_b} !== {e[68:64], e[31:0]} || cyc - int'(e[100:69]) != 1) begin
                    errors++;
                    $display("FAIL dut_b result: rd=%h fflags=%b latency=%0d, expected rd=%h fflags=%b latency=1",
                             rd_b, ff_b, cyc - int'(e[100:69]), e[31:0], e[68:64]);
                end
            end
        end
        if (done_c) begin
            checks++;
            if (exp_q_c.size() == 0) begin
                errors++;
                $display("FAIL dut_c unexpected done: rd=%h", rd_c);
            end else begin
                e = exp_q_c.pop_front();
                if ({ff_c, rd_c} !== {e[68:64], e[7:0]} || cyc - int'(e[100:69]) != 2) begin
                    errors++;
                    $display("FAIL dut_c result: rd=%h fflags=%b latency=%0d, expected rd=%h fflags=%b latency=2",
                             rd_c, ff_c, cyc - int'(e[100:69]), e[7:0], e[68:64]);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive one op for one cycle; has_exp selects a hand-derived 32-bit result over the model.
    task automatic issue(input logic [31:0] a, input logic [2:0] m, input logic u,
                         input logic has_exp, input logic [31:0] e_rd, input logic [4:0] e_ff);
        logic [68:0] m32, m8;
        rs1 = a;
        rm = m;
        is_unsigned = u;
        order = 1'b1;
        m32 = model(a, m, u, 32);
        m8  = model(a, m, u, 8);
        if (has_exp) m32 = {e_ff, 32'd0, e_rd};
        m32[68:64] = mask_flags(m32[68:64]);
        m8[68:64]  = mask_flags(m8[68:64]);
        exp_q_a.push_back({32'(cyc), m32});
        exp_q_b.push_back({32'(cyc), m32});
        exp_q_c.push_back({32'(cyc), m8});
        #1;
        checks++;
        if ({acc_a, acc_b, acc_c} !== 3'b111) begin
            errors++;
            $display("FAIL accepted: got %b, expected 111", {acc_a, acc_b, acc_c});
        end
        tick();
    endtask

    task automatic drain();
        order = 1'b0;
        for (int i = 0; i < 8 && (exp_q_a.size() + exp_q_b.size() + exp_q_c.size()) != 0; i++) tick();
        checks++;
        if ((exp_q_a.size() + exp_q_b.size() + exp_q_c.size()) != 0) begin
            errors++;
            $display("FAIL drain timeout: pending a=%0d b=%0d c=%0d, expected 0",
                     exp_q_a.size(), exp_q_b.size(), exp_q_c.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        order = 1'b1;
        rs1 = 32'h3F800000;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({acc_a, acc_b, acc_c, done_a, done_b, done_c} !== 6'b0 || rd_a !== 32'd0 ||
                rd_b !== 32'd0 || rd_c !== 8'd0 || {ff_a, ff_b, ff_c} !== 15'd0) begin
                errors++;
                $display("FAIL reset state: acc=%b done=%b rd=%h/%h/%h, expected all 0",
                         {acc_a, acc_b, acc_c}, {done_a, done_b, done_c}, rd_a, rd_b, rd_c);
            end
        end
        order = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_rounding();
        issue(32'h40200000, 3'd0, 1'b0, 1'b1, 32'd2, 5'h01);
        issue(32'h40200000, 3'd3, 1'b0, 1'b1, 32'd3, 5'h01);
        issue(32'h40200000, 3'd4, 1'b0, 1'b1, 32'd3, 5'h01);
        issue(32'h40200000, 3'd1, 1'b0, 1'b1, 32'd2, 5'h01);
        issue(32'h40200000, 3'd7, 1'b0, 1'b1, 32'd2, 5'h01);
        issue(32'hC0200000, 3'd0, 1'b0, 1'b1, 32'hFFFFFFFE, 5'h01);
        issue(32'hC0200000, 3'd2, 1'b0, 1'b1, 32'hFFFFFFFD, 5'h01);
        issue(32'hC0200000, 3'd4, 1'b0, 1'b1, 32'hFFFFFFFD, 5'h01);
        issue(32'h3FC00000, 3'd0, 1'b0, 1'b1, 32'd2, 5'h01);
        issue(32'h3F000000, 3'd0, 1'b0, 1'b1, 32'd0, 5'h01);
        issue(32'h3F000000, 3'd3, 1'b0, 1'b1, 32'd1, 5'h01);
        issue(32'h00000001, 3'd2, 1'b0, 1'b1, 32'd0, 5'h01);
        issue(32'h80000001, 3'd2, 1'b0, 1'b1, 32'hFFFFFFFF, 5'h01);
        issue(32'h00000000, 3'd0, 1'b0, 1'b1, 32'd0, 5'h00);
        issue(32'hC3008000, 3'd0, 1'b0, 1'b1, 32'hFFFFFF80, 5'h01);
        issue(32'hC3008000, 3'd4, 1'b0, 1'b1, 32'hFFFFFF7F, 5'h01);
        drain();
    endtask

    task automatic test_saturation();
        issue(32'h4F32D05E, 3'd0, 1'b0, 1'b1, 32'h7FFFFFFF, 5'h10);
        issue(32'h4F32D05E, 3'd0, 1'b1, 1'b1, 32'hB2D05E00, 5'h00);
        issue(32'hBF400000, 3'd0, 1'b1, 1'b1, 32'd0, 5'h10);
        issue(32'hBF400000, 3'd1, 1'b1, 1'b1, 32'd0, 5'h01);
        issue(32'h7FC00000, 3'd0, 1'b0, 1'b1, 32'h7FFFFFFF, 5'h10);
        issue(32'hFFC00000, 3'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 5'h10);
        issue(32'hCF000000, 3'd0, 1'b0, 1'b1, 32'h80000000, 5'h00);
        issue(32'h4F000000, 3'd0, 1'b0, 1'b1, 32'h7FFFFFFF, 5'h10);
        issue(32'hFF800000, 3'd0, 1'b0, 1'b1, 32'h80000000, 5'h10);
        issue(32'hFF800000, 3'd0, 1'b1, 1'b1, 32'd0, 5'h10);
        issue(32'h7F800000, 3'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 5'h10);
        issue(32'h4F7FFFFF, 3'd0, 1'b1, 1'b1, 32'hFFFFFF00, 5'h00);
        issue(32'h42FF0000, 3'd0, 1'b0, 1'b1, 32'd128, 5'h01);
        issue(32'h437F8000, 3'd3, 1'b1, 1'b1, 32'd256, 5'h01);
        issue(32'hC3000000, 3'd0, 1'b0, 1'b1, 32'hFFFFFF80, 5'h00);
        drain();
    endtask

    task automatic test_back_to_back();
        issue(32'h3F800000, 3'd0, 1'b0, 1'b1, 32'd1, 5'h00);
        issue(32'h40000000, 3'd0, 1'b0, 1'b1, 32'd2, 5'h00);
        issue(32'h40400000, 3'd0, 1'b0, 1'b1, 32'd3, 5'h00);
        issue(32'h40800000, 3'd0, 1'b0, 1'b1, 32'd4, 5'h00);
        drain();
    endtask

    task automatic test_hold();
        issue(32'h41100000, 3'd0, 1'b0, 1'b1, 32'd9, 5'h00);
        drain();
        repeat (3) begin
            tick();
            checks++;
            if (rd_a !== 32'd9 || rd_b !== 32'd9 || rd_c !== 8'd9 || {done_a, done_b, done_c} !== 3'b0) begin
                errors++;
                $display("FAIL hold: rd=%h/%h/%h done=%b, expected rd=9 done=000",
                         rd_a, rd_b, rd_c, {done_a, done_b, done_c});
            end
        end
    endtask

    task automatic test_reset_mid();
        issue(32'h40A00000, 3'd0, 1'b0, 1'b1, 32'd5, 5'h00);
        rstn = 1'b0;
        order = 1'b1;
        rs1 = 32'h40C00000;
        exp_q_a.delete();
        exp_q_b.delete();
        exp_q_c.delete();
        repeat (2) begin
            #1;
            checks++;
            if ({acc_a, acc_b, acc_c, done_a, done_b, done_c} !== 6'b0 ||
                rd_a !== 32'd0 || rd_b !== 32'd0 || rd_c !== 8'd0) begin
                errors++;
                $display("FAIL reset mid-op: acc=%b done=%b rd=%h/%h/%h, expected all 0",
                         {acc_a, acc_b, acc_c}, {done_a, done_b, done_c}, rd_a, rd_b, rd_c);
            end
            tick();
        end
        order = 1'b0;
        rstn = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({done_a, done_b, done_c} !== 3'b0 || rd_a !== 32'd0 || rd_b !== 32'd0 || rd_c !== 8'd0) begin
                errors++;
                $display("FAIL after reset: done=%b rd=%h/%h/%h, expected 0",
                         {done_a, done_b, done_c}, rd_a, rd_b, rd_c);
            end
        end
        issue(32'h40C00000, 3'd0, 1'b0, 1'b1, 32'd6, 5'h00);
        drain();
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 240; i++) begin
            a = $urandom;
            a[30:23] = 8'($urandom_range(100, 170));
            if ($urandom_range(0, 15) == 0) a[30:23] = 8'hFF;
            else if ($urandom_range(0, 15) == 0) a[30:23] = 8'h00;
            if ($urandom_range(0, 2) == 0) a[14:0] = '0;
            if ($urandom_range(0, 3) == 0) begin
                order = 1'b0;
                tick();
            end
            issue(a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 32'd0, 5'h00);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
